// File: rtl/rewire_io_pkg.sv
// Shared types and helpers for the bit deserializer and its word FIFO.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rewire_io_pkg;

  // Largest supported FIFO depth; sizes the generic occupancy type.
  localparam int MAX_DEPTH = 16;

  // Occupancy count wide enough for any supported depth (0..MAX_DEPTH).
  typedef logic [$clog2(MAX_DEPTH):0] fifo_cnt_t;

  // Order in which serial bits are placed into the assembled word.
  typedef enum logic {
    ORD_LSB_FIRST = 1'b0,
    ORD_MSB_FIRST = 1'b1
  } bit_order_e;

  // Index width for a counter/pointer over n states; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO with occupancy count; head word reads as 0 when empty.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: push while full is accepted only if a pop happens at the same edge.
module sync_word_fifo
  import rewire_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = cnt_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam fifo_cnt_t DEPTH_CNT = fifo_cnt_t'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (fifo_cnt_t'(r_count) == DEPTH_CNT);
  assign o_count    = r_count;
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  // A full FIFO can still take a word when the head leaves at the same edge.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (rst && w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/bit_deserializer.sv
// Assembles WIDTH serial bits into words and queues them for a valid/ready consumer.
// Latency: word_valid rises the cycle after the edge capturing the last bit.
// Backpressure: words completing into a full FIFO (no pop) are dropped and set sticky overflow.
module bit_deserializer
  import rewire_io_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_en,
  output logic [WIDTH-1:0]       word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int         CW    = cnt_w(WIDTH);
  localparam bit_order_e ORDER = (MSB_FIRST != 0) ? ORD_MSB_FIRST : ORD_LSB_FIRST;

  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_overflow;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  // Next shift-register value with the incoming bit placed per bit order.
  generate
    if (ORDER == ORD_MSB_FIRST) begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign w_shift_nxt = {bit_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // The completing bit is pushed together with the rest of the word at the same edge.
  assign w_last = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_push = bit_en & w_last;
  assign w_pop  = word_ready & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  // Bit counter and shift register advance only on qualified bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (bit_en) begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  sync_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_shift_nxt),
    .i_pop      (w_pop),
    .o_head_dat (word_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (fill_level)
  );

  assign word_valid = ~w_empty;
  assign overflow   = r_overflow;

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Downstream consumer of the generated single-bit resumption core (clk/rst/__in0/__out0 top level).
- Takes the core's one-bit-per-cycle output (__out0) and assembles WIDTH bits into a word.
- Buffers assembled words in a small FIFO and presents them on a valid/ready interface to the host side.
- Flags words lost to back-pressure with a sticky overflow bit.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- DEPTH, 2, FIFO entries (power of two, 2..16).
- MSB_FIRST, 1, 1: first received bit lands in word_data[WIDTH-1]; 0: first bit lands in word_data[0].

Ports:
- clk  input  1  system clock, same clock as the core.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- bit_in  input  1  serial bit, driven from core __out0.
- bit_en  input  1  qualifies bit_in; a bit is consumed only when bit_en=1.
- word_data  output  WIDTH  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts the word when word_valid & word_ready.
- overflow  output  1  sticky; a completed word was dropped.
- ovf_clr  input  1  clears overflow.
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0 at posedge): bit counter=0, shift register=0, FIFO empty, word_valid=0, word_data=0, overflow=0, fill_level=0. Reset in mid-word discards the partial word. Reset in mid-stream empties the FIFO without output.
- Assembly:
  - On each posedge with bit_en=1, shift bit_in into the shift register. Direction follows MSB_FIRST.
  - The counter increments modulo WIDTH.
  - bit_en=0 holds the counter and the register unchanged.
- Completion: a posedge with bit_en=1 and counter=WIDTH-1 is the WIDTH-th bit.
  - The full word, including this bit, is pushed into the FIFO at that same edge.
  - The counter returns to 0.
- Latency: word_valid rises, and word_data shows the word, in the cycle after the edge that captured the WIDTH-th bit (1 cycle).
- Pop: at a posedge with word_valid=1 and word_ready=1, the head is removed. The next entry, or nothing, shows on the following cycle.
- word_data is don't-care-free: it is 0 when empty.
- Push while full:
  - If a pop happens at the same edge, the push succeeds and fill_level stays at DEPTH.
  - With no pop, the new word is dropped, FIFO contents are unchanged, and overflow sets at that edge.
- Push while empty with word_ready=1 at the same edge: the push succeeds and the word is NOT bypassed. word_valid rises next cycle (no combinational path from bit_in to word_valid).
- overflow: set has priority over ovf_clr when both happen at the same edge. Otherwise ovf_clr=1 clears it.
- fill_level = push − pop accounting, range 0..DEPTH. It never wraps.
- word_ready is ignored while word_valid=0. The FIFO pointers wrap modulo DEPTH.
- All outputs are registered or derived only from registered state.

Decomposition:
- Shared package rewire_io_pkg holds:
  - typedef for the FIFO occupancy count;
  - localparam helpers for counter width ($clog2(WIDTH));
  - the enum for bit order (MSB_FIRST/LSB_FIRST).
- One sub-module, sync_word_fifo:
  - parameters WIDTH and DEPTH;
  - push/pop/full/empty/count;
  - same clk/rst conventions.
- Assembly counter, shift register and overflow logic stay in bit_deserializer.

Test Plan:
- Reset then WIDTH=8, MSB_FIRST=1, bit_en=1, bits 1,0,1,0,0,1,0,1, word_ready=1 -> word_valid=1 exactly one cycle after the 8th bit, word_data=8'hA5, then valid drops.
- MSB_FIRST=0, same bit sequence -> word_data=8'hA5 bit-reversed = 8'hA5 (palindrome check), then sequence 1,1,0,0,0,0,0,0 -> 8'h03.
- bit_en toggled 1,0,1,0... across 16 cycles with bits 1..1 -> exactly one word 8'hFF, with no partial word emitted.
- word_ready=0, DEPTH=2, stream 3 words 8'h11,8'h22,8'h33 -> fill_level=2, overflow=1 after the 3rd word. Drain yields 8'h11 then 8'h22. ovf_clr=1 -> overflow=0.
- Full FIFO, word_ready=1 at the same edge the next word completes -> no overflow, fill_level stays 2, order preserved.
- rst=0 asserted after 5 of 8 bits, then released, then 8 bits of 8'h5A -> only 8'h5A emitted, fill_level=0 during reset.
